// File: rtl/control_sequencer_if.sv
// Datapath control interface: the sequencer (master) produces every control,
// the datapath (slave) supplies the run level and the IR contents.
interface control_sequencer_if #(
  parameter int OPW  = 5,
  parameter int NREG = 16
);
  logic            run;
  logic [31:0]     ir;
  logic            PCout;
  logic            pc_increment;
  logic            MARin;
  logic            PCin;
  logic            read;
  logic            MDRin;
  logic            MDRout;
  logic            IRin;
  logic            RYin;
  logic            Zlowin;
  logic            Zhighin;
  logic            Zlowout;
  logic            Zhighout;
  logic            LOin;
  logic            HIin;
  logic [NREG-1:0] reg_in;
  logic [NREG-1:0] reg_out;
  logic [OPW-1:0]  op_code;
  logic [3:0]      state;
  logic            halted;
  logic            illegal;

  modport master (
    input  run, ir,
    output PCout, pc_increment, MARin, PCin, read, MDRin, MDRout, IRin, RYin,
    output Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
    output reg_in, reg_out, op_code, state, halted, illegal
  );

  modport slave (
    output run, ir,
    input  PCout, pc_increment, MARin, PCin, read, MDRin, MDRout, IRin, RYin,
    input  Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
    input  reg_in, reg_out, op_code, state, halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the datapath: fetch (T0-T2) then
// decode/execute (T3-T6) for three-register ALU, mul/div and unary ops.
// Controls are a decode of the state register and the latched IR fields,
// except in T3, where the IR has only just loaded and is decoded live.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int NREG = 16
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0000,
    S_T0   = 4'b0111,
    S_T1   = 4'b1000,
    S_T2   = 4'b1001,
    S_T3   = 4'b1010,
    S_T4   = 4'b1011,
    S_T5   = 4'b1100,
    S_T6   = 4'b1101,
    S_HALT = 4'b1110
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU3 = 3'd0,
    CL_MD   = 3'd1,
    CL_UN   = 3'd2,
    CL_NOP  = 3'd3,
    CL_HLT  = 3'd4,
    CL_ILL  = 3'd5
  } cls_t;

  localparam logic [NREG-1:0] ONE_HOT_R0 = {{(NREG-1){1'b0}}, 1'b1};

  state_t         r_state;
  logic [OPW-1:0] r_opc;
  logic [3:0]     r_ra;
  logic [3:0]     r_rb;
  logic [3:0]     r_rc;
  cls_t           w_live_cls;
  cls_t           w_lat_cls;

  // Instruction class from the opcode; anything not listed is illegal.
  function automatic cls_t f_classify(input logic [OPW-1:0] opc);
    cls_t cls;
    if ((opc >= 5'b00011) && (opc <= 5'b01011)) begin
      cls = CL_ALU3;
    end else if ((opc == 5'b01111) || (opc == 5'b10000)) begin
      cls = CL_MD;
    end else if ((opc == 5'b10001) || (opc == 5'b10010)) begin
      cls = CL_UN;
    end else if (opc == 5'b11010) begin
      cls = CL_NOP;
    end else if (opc == 5'b11011) begin
      cls = CL_HLT;
    end else begin
      cls = CL_ILL;
    end
    return cls;
  endfunction

  // One-hot register select for a 4-bit register number.
  function automatic logic [NREG-1:0] f_onehot(input logic [3:0] idx);
    return ONE_HOT_R0 << idx;
  endfunction

  assign w_live_cls = f_classify(bus.ir[31:27]);
  assign w_lat_cls  = f_classify(r_opc);
  assign bus.state  = r_state;

  // State sequencing; IR fields are captured on the T3->T4 edge, when IR is valid.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_opc   <= {OPW{1'b0}};
      r_ra    <= 4'd0;
      r_rb    <= 4'd0;
      r_rc    <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= bus.run ? S_T0 : S_IDLE;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_T3: begin
          r_opc <= bus.ir[31:27];
          r_ra  <= bus.ir[26:23];
          r_rb  <= bus.ir[22:19];
          r_rc  <= bus.ir[18:15];
          case (w_live_cls)
            CL_ALU3, CL_MD, CL_UN: r_state <= S_T4;
            CL_HLT:                r_state <= S_HALT;
            default:               r_state <= S_IDLE;
          endcase
        end
        S_T4:    r_state <= S_T5;
        S_T5:    r_state <= (w_lat_cls == CL_MD) ? S_T6 : S_IDLE;
        S_T6:    r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Control decode: everything defaults low, each step raises only its own controls.
  always_comb begin
    bus.PCout        = 1'b0;
    bus.pc_increment = 1'b0;
    bus.MARin        = 1'b0;
    bus.PCin         = 1'b0;
    bus.read         = 1'b0;
    bus.MDRin        = 1'b0;
    bus.MDRout       = 1'b0;
    bus.IRin         = 1'b0;
    bus.RYin         = 1'b0;
    bus.Zlowin       = 1'b0;
    bus.Zhighin      = 1'b0;
    bus.Zlowout      = 1'b0;
    bus.Zhighout     = 1'b0;
    bus.LOin         = 1'b0;
    bus.HIin         = 1'b0;
    bus.reg_in       = {NREG{1'b0}};
    bus.reg_out      = {NREG{1'b0}};
    bus.op_code      = {OPW{1'b0}};
    bus.halted       = 1'b0;
    bus.illegal      = 1'b0;
    case (r_state)
      S_T0: begin
        bus.PCout        = 1'b1;
        bus.pc_increment = 1'b1;
        bus.MARin        = 1'b1;
        bus.Zlowin       = 1'b1;
        bus.Zhighin      = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        case (w_live_cls)
          CL_ALU3, CL_MD, CL_UN: begin
            bus.reg_out = f_onehot(bus.ir[22:19]);
            bus.RYin    = 1'b1;
          end
          CL_ILL:  bus.illegal = 1'b1;
          default: bus.RYin    = 1'b0;
        endcase
      end
      S_T4: begin
        bus.reg_out = f_onehot((w_lat_cls == CL_UN) ? r_rb : r_rc);
        bus.op_code = r_opc;
        bus.Zlowin  = 1'b1;
        bus.Zhighin = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (w_lat_cls == CL_MD) begin
          bus.LOin = 1'b1;
        end else begin
          bus.reg_in = f_onehot(r_ra);
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instructions from the test plan plus
// randomized instruction/run streams, all checked cycle by cycle against a
// queue-of-steps reference model built from the instruction's class.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic clr;

  control_sequencer_if #(.OPW(5), .NREG(16)) u_if ();

  control_sequencer #(.OPW(5), .NREG(16)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  // control bit positions in the packed expectation vector
  localparam int C_PCOUT = 0,  C_PCINC = 1,  C_MARIN = 2,  C_PCIN   = 3,  C_READ = 4;
  localparam int C_MDRIN = 5,  C_MDROUT = 6, C_IRIN = 7,   C_RYIN   = 8,  C_ZLIN = 9;
  localparam int C_ZHIN  = 10, C_ZLOUT = 11, C_ZHOUT = 12, C_LOIN   = 13, C_HIIN = 14;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        hlt;
    logic        ill;
    logic        go_halt;
  } exp_t;

  exp_t q[$];
  bit   m_halt;
  int   n_checks;
  int   n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] bits(input int a, input int b, input int c, input int d, input int e);
    logic [14:0] one;
    logic [14:0] v;
    one = 15'd1;
    v = 15'd0;
    if (a >= 0) v = v | (one << a);
    if (b >= 0) v = v | (one << b);
    if (c >= 0) v = v | (one << c);
    if (d >= 0) v = v | (one << d);
    if (e >= 0) v = v | (one << e);
    return v;
  endfunction

  function automatic exp_t mk(input logic [3:0] st, input logic [14:0] ctl);
    exp_t e;
    e.st = st; e.ctl = ctl; e.rin = 16'd0; e.rout = 16'd0;
    e.op = 5'd0; e.hlt = 1'b0; e.ill = 1'b0; e.go_halt = 1'b0;
    return e;
  endfunction

  // Expand one instruction into the list of cycles it should produce from T0 on.
  task automatic build(input logic [31:0] ir);
    int opc, ra, rb, rc;
    bit is_alu, is_md, is_un, is_hlt, is_nop;
    logic [15:0] one;
    exp_t e;
    one = 16'd1;
    opc = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    is_alu = (opc >= 3) && (opc <= 11);
    is_md  = (opc == 15) || (opc == 16);
    is_un  = (opc == 17) || (opc == 18);
    is_nop = (opc == 26);
    is_hlt = (opc == 27);
    q.push_back(mk(4'd7, bits(C_PCOUT, C_PCINC, C_MARIN, C_ZLIN, C_ZHIN)));
    q.push_back(mk(4'd8, bits(C_ZLOUT, C_PCIN, C_READ, C_MDRIN, -1)));
    q.push_back(mk(4'd9, bits(C_MDROUT, C_IRIN, -1, -1, -1)));
    e = mk(4'd10, 15'd0);
    if (is_alu || is_md || is_un) begin
      e.ctl = bits(C_RYIN, -1, -1, -1, -1);
      e.rout = one << rb;
    end else if (is_hlt) begin
      e.go_halt = 1'b1;
    end else if (!is_nop) begin
      e.ill = 1'b1;
    end
    q.push_back(e);
    if (is_alu || is_md || is_un) begin
      e = mk(4'd11, bits(C_ZLIN, C_ZHIN, -1, -1, -1));
      e.rout = one << (is_un ? rb : rc);
      e.op = 5'(opc);
      q.push_back(e);
      if (is_md) begin
        q.push_back(mk(4'd12, bits(C_ZLOUT, C_LOIN, -1, -1, -1)));
        q.push_back(mk(4'd13, bits(C_ZHOUT, C_HIIN, -1, -1, -1)));
      end else begin
        e = mk(4'd12, bits(C_ZLOUT, -1, -1, -1, -1));
        e.rin = one << ra;
        q.push_back(e);
      end
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    if (q.size() > 0) begin
      e = q[0];
    end else if (m_halt) begin
      e = mk(4'd14, 15'd0);
      e.hlt = 1'b1;
    end else begin
      e = mk(4'd0, 15'd0);
    end
    return e;
  endfunction

  function automatic logic [14:0] obs_ctl();
    logic [14:0] v;
    v = 15'd0;
    v[C_PCOUT] = u_if.PCout;   v[C_PCINC] = u_if.pc_increment; v[C_MARIN] = u_if.MARin;
    v[C_PCIN]  = u_if.PCin;    v[C_READ]  = u_if.read;         v[C_MDRIN] = u_if.MDRin;
    v[C_MDROUT] = u_if.MDRout; v[C_IRIN]  = u_if.IRin;         v[C_RYIN]  = u_if.RYin;
    v[C_ZLIN]  = u_if.Zlowin;  v[C_ZHIN]  = u_if.Zhighin;      v[C_ZLOUT] = u_if.Zlowout;
    v[C_ZHOUT] = u_if.Zhighout; v[C_LOIN] = u_if.LOin;         v[C_HIIN]  = u_if.HIin;
    return v;
  endfunction

  task automatic check_cur();
    exp_t e;
    int drv;
    e = cur_exp();
    check_val("state",   32'(u_if.state),   32'(e.st));
    check_val("ctl",     32'(obs_ctl()),    32'(e.ctl));
    check_val("reg_in",  32'(u_if.reg_in),  32'(e.rin));
    check_val("reg_out", 32'(u_if.reg_out), 32'(e.rout));
    check_val("op_code", 32'(u_if.op_code), 32'(e.op));
    check_val("halted",  32'(u_if.halted),  32'(e.hlt));
    check_val("illegal", 32'(u_if.illegal), 32'(e.ill));
    drv = int'(u_if.PCout) + int'(u_if.MDRout) + int'(u_if.Zlowout) + int'(u_if.Zhighout)
          + $countones(u_if.reg_out);
    check_val("one_driver", 32'(drv <= 1), 32'd1);
    check_val("in_out_excl", 32'((u_if.reg_in != 16'd0) && (u_if.reg_out != 16'd0)), 32'd0);
  endtask

  // Advance the model over the coming edge using the inputs currently driven.
  task automatic model_advance();
    if (q.size() > 0) begin
      if (q[0].go_halt) m_halt = 1'b1;
      void'(q.pop_front());
    end else if (!m_halt && u_if.run) begin
      build(u_if.ir);
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    check_cur();
  endtask

  // Async reset pulse placed mid-cycle, away from any edge.
  task automatic do_reset();
    #2 clr = 1'b0;
    #1;
    q.delete();
    m_halt = 1'b0;
    check_cur();
    @(posedge clk);
    @(negedge clk);
    check_cur();
    clr = 1'b1;
  endtask

  // One instruction: run high for a single sample, then low; measure DUT latency.
  task automatic run_instr(input logic [31:0] ir, input int exp_len,
                           input logic [15:0] exp_rin, input int exp_ill);
    int n;
    int n_ill;
    logic [15:0] acc;
    n = 0; n_ill = 0; acc = 16'd0;
    u_if.ir = ir;
    u_if.run = 1'b1;
    tick();
    u_if.run = 1'b0;
    while ((u_if.state != 4'd0) && (n < 30)) begin
      n++;
      acc = acc | u_if.reg_in;
      n_ill += int'(u_if.illegal);
      tick();
    end
    check_val("latency", 32'(n), 32'(exp_len));
    check_val("reg_in_seen", 32'(acc), 32'(exp_rin));
    check_val("illegal_cycles", 32'(n_ill), 32'(exp_ill));
  endtask

  initial begin
    logic [31:0] r;
    n_checks = 0; n_fail = 0; m_halt = 1'b0;
    clr = 1'b0; u_if.run = 1'b0; u_if.ir = 32'd0;
    @(negedge clk);
    check_cur();
    clr = 1'b1;
    tick();
    tick();

    run_instr(32'h4A988000, 6, 16'h0020, 0);
    run_instr(32'h80900000, 7, 16'h0000, 0);
    run_instr(32'h89180000, 6, 16'h0004, 0);
    run_instr(32'h91180000, 6, 16'h0004, 0);
    run_instr(32'hF8000000, 4, 16'h0000, 1);
    run_instr(32'hD0000000, 4, 16'h0000, 0);
    run_instr((32'd3 << 27) | (32'd5 << 23) | (32'd5 << 19) | (32'd5 << 15), 6, 16'h0020, 0);
    run_instr(32'h78000000, 7, 16'h0000, 0);

    // abort mid-T4
    u_if.ir = 32'h4A988000;
    u_if.run = 1'b1;
    tick();
    u_if.run = 1'b0;
    for (int i = 0; (i < 10) && (u_if.state != 4'b1011); i++) tick();
    check_val("reach_t4", 32'(u_if.state), 32'hb);
    do_reset();
    for (int i = 0; i < 4; i++) tick();

    // halt holds with run high, left only via reset
    u_if.ir = 32'hD8000000;
    u_if.run = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check_val("halt_state", 32'(u_if.state), 32'he);
    check_val("halt_flag", 32'(u_if.halted), 32'd1);
    do_reset();
    u_if.run = 1'b0;
    tick();

    // random instruction / run stream
    for (int i = 0; i < 500; i++) begin
      if (q.size() == 0) begin
        r = $urandom;
        if ($urandom_range(0, 2) != 0) r[31:27] = 5'($urandom_range(3, 18));
        if (r[31:27] == 5'd27) r[31:27] = 5'd26;
        u_if.ir = r;
      end
      u_if.run = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
